// File: rtl/riscv_fetch_pkg.sv
// Shared types and constants for the instruction fetch sequencer.
// Holds the fetch FSM state encoding and the default reset/trap addresses.
package riscv_fetch_pkg;

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    VALID,
    DRAIN
  } fetch_state_t;

  localparam int unsigned INSTR_BYTES         = 4;
  localparam logic [31:0] DEFAULT_RESET_ADDR  = 32'h0000_0000;
  localparam logic [31:0] DEFAULT_TRAP_VECTOR = 32'h0000_0004;

  function automatic logic is_aligned(input logic [31:0] addr);
    return addr[1:0] == 2'b00;
  endfunction

endpackage

// File: rtl/pc_next_sel.sv
// Combinational next-PC selector: trap beats redirect beats sequential.
// A misaligned redirect target is replaced by the trap vector and flagged.
module pc_next_sel
  import riscv_fetch_pkg::*;
#(
  parameter logic [31:0] TRAP_VECTOR = DEFAULT_TRAP_VECTOR
) (
  input  logic [31:0] cur_addr,
  input  logic        trap,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_target,
  output logic [31:0] next_addr,
  output logic        take_redirect,
  output logic        misalign
);

  always_comb begin
    next_addr     = cur_addr + 32'(INSTR_BYTES);
    take_redirect = trap | redirect_valid;
    misalign      = 1'b0;
    if (trap) begin
      next_addr = TRAP_VECTOR;
    end else if (redirect_valid) begin
      if (is_aligned(redirect_target)) begin
        next_addr = redirect_target;
      end else begin
        next_addr = TRAP_VECTOR;
        misalign  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/pc_fetch_sequencer.sv
// Fetch-side controller: owns the PC, issues one imem request at a time and
// hands fetched instructions to decode, applying redirects and trap entry.
module pc_fetch_sequencer
  import riscv_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_ADDR  = DEFAULT_RESET_ADDR,
  parameter logic [31:0] TRAP_VECTOR = DEFAULT_TRAP_VECTOR
) (
  input  logic        clk,
  input  logic        reset_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic        inst_valid,
  output logic [31:0] inst,
  output logic [31:0] inst_pc,
  input  logic        inst_ready,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_target,
  input  logic        trap,
  output logic        misalign_err
);

  fetch_state_t state;
  logic [31:0]  pc;
  logic [31:0]  fetch_addr;
  logic [31:0]  next_addr;
  logic         take_redirect;
  logic         misalign;

  assign imem_addr = fetch_addr;

  // Sequential candidate is fetch_addr + 4; only consumed when FETCH accepts data.
  pc_next_sel #(
    .TRAP_VECTOR(TRAP_VECTOR)
  ) u_pc_next_sel (
    .cur_addr       (fetch_addr),
    .trap           (trap),
    .redirect_valid (redirect_valid),
    .redirect_target(redirect_target),
    .next_addr      (next_addr),
    .take_redirect  (take_redirect),
    .misalign       (misalign)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state        <= IDLE;
      pc           <= RESET_ADDR;
      fetch_addr   <= RESET_ADDR;
      imem_req     <= 1'b0;
      inst_valid   <= 1'b0;
      inst         <= '0;
      inst_pc      <= '0;
      misalign_err <= 1'b0;
    end else begin
      misalign_err <= misalign;
      unique case (state)
        IDLE: begin
          if (take_redirect) begin
            fetch_addr <= next_addr;
            pc         <= next_addr;
          end
          state    <= FETCH;
          imem_req <= 1'b1;
        end

        FETCH: begin
          if (take_redirect) begin
            pc <= next_addr;
            if (imem_ack) begin
              // Data for the old path is dropped; new request goes out next cycle.
              fetch_addr <= next_addr;
            end else begin
              state <= DRAIN;
            end
          end else if (imem_ack) begin
            inst       <= imem_rdata;
            inst_pc    <= fetch_addr;
            pc         <= next_addr;
            imem_req   <= 1'b0;
            inst_valid <= 1'b1;
            state      <= VALID;
          end
        end

        VALID: begin
          if (take_redirect) begin
            fetch_addr <= next_addr;
            pc         <= next_addr;
            inst_valid <= 1'b0;
            imem_req   <= 1'b1;
            state      <= FETCH;
          end else if (inst_ready) begin
            fetch_addr <= pc;
            inst_valid <= 1'b0;
            imem_req   <= 1'b1;
            state      <= FETCH;
          end
        end

        DRAIN: begin
          // The stale request must still complete before the new path starts.
          if (take_redirect) begin
            pc <= next_addr;
          end
          if (imem_ack) begin
            fetch_addr <= take_redirect ? next_addr : pc;
            state      <= FETCH;
          end
        end

        default: begin
          state      <= IDLE;
          imem_req   <= 1'b0;
          inst_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/pc_fetch_sequencer.md
# pc_fetch_sequencer

Fetch-side controller that owns the program counter and sequences instruction fetches from instruction memory. It holds the current PC, issues one request at a time over a req/ack handshake, and presents fetched instructions to decode over a valid/ready handshake. It applies branch/jump redirects and trap entry with defined priority. It sits between the branch-resolution logic and the instruction memory, and replaces the free-running PC stage.

## Interface
- `RESET_ADDR`, default 32'h0000_0000, PC value loaded on reset.
- `TRAP_VECTOR`, default 32'h0000_0004, PC loaded on trap or on a misaligned redirect.
- `clk` input 1: single clock; all state updates on rising edge.
- `reset_n` input 1: reset is asynchronous and active-low.
- `imem_req` output 1: fetch request; held until acknowledged.
- `imem_addr` output 32: fetch address; stable while `imem_req`=1.
- `imem_ack` input 1: request accepted; `imem_rdata` valid in the same cycle.
- `imem_rdata` input 32: instruction word.
- `inst_valid` output 1: `inst` and `inst_pc` valid for decode.
- `inst` output 32: fetched instruction.
- `inst_pc` output 32: address of `inst`.
- `inst_ready` input 1: decode accepts `inst` when `inst_valid`&`inst_ready`.
- `redirect_valid` input 1: one-cycle pulse, taken branch/jump resolved.
- `redirect_target` input 32: new PC.
- `trap` input 1: one-cycle pulse, enter `TRAP_VECTOR`.
- `misalign_err` output 1: one-cycle pulse when `redirect_target[1:0]`≠0.

## Operation
- Registers: `pc` (next address to fetch), `fetch_addr` (address of the outstanding request), `state`, `inst`, `inst_pc`.
- States:
  - IDLE: reset state; always goes to FETCH after one cycle.
  - FETCH: `imem_req`=1, `imem_addr`=`fetch_addr`. On ack, capture `imem_rdata`→`inst`, `fetch_addr`→`inst_pc`, set `pc`←`fetch_addr`+4, and go to VALID.
  - VALID: `inst_valid`=1. On `inst_ready`, set `fetch_addr`←`pc` and go to FETCH.
  - DRAIN: a redirect arrived while a request was outstanding. Keep `imem_req`=1 at the old `fetch_addr`. On ack, discard the data, set `fetch_addr`←`pc` (the redirect target), and go to FETCH.
- Redirect source priority: `trap` > `redirect_valid` > sequential. The target is `TRAP_VECTOR` for a trap, else `redirect_target`. A misaligned `redirect_target` pulses `misalign_err` and uses `TRAP_VECTOR`.
- Redirect in FETCH without ack: `pc`←target, go to DRAIN.
- Redirect in FETCH with ack in the same cycle: discard the data, set `fetch_addr`←target, stay in FETCH (the new request starts the next cycle).
- Redirect in VALID: `inst_valid` drops next cycle, `fetch_addr`←target, go to FETCH. If `inst_ready` is also high, the handshake counts as completed; otherwise the instruction is dropped.
- Redirect in DRAIN: `pc`←newest target; stay in DRAIN.
- Redirect in IDLE: `fetch_addr`←target, go to FETCH.
- Arithmetic: `pc`+4 is modulo 2^32, so 32'hFFFF_FFFC wraps to 0. Addresses are always 4-aligned.

## Timing
- Reset values: `state`=IDLE; `pc`=`fetch_addr`=`RESET_ADDR`; `imem_req`=0; `inst_valid`=0; `inst`=0; `inst_pc`=0; `misalign_err`=0.
- Asserting `reset_n` mid-request drops `imem_req` immediately. Any later ack is ignored until FETCH is re-entered.
- The first `imem_req` appears in the 2nd cycle after reset deassertion.
- Best-case throughput is one instruction per 2 cycles (FETCH with an immediate ack, then VALID with an immediate ready).
- `inst_valid` rises the cycle after the accepting ack.
- `misalign_err` is registered and pulses in the cycle after the redirect.
- All outputs are registered except `imem_addr`, which is driven from the `fetch_addr` register.

## Structure
- Package `riscv_fetch_pkg` holds:
  - the state enum `fetch_state_t` {IDLE, FETCH, VALID, DRAIN};
  - the constant `INSTR_BYTES`=4;
  - the defaults for `RESET_ADDR` and `TRAP_VECTOR`.
- One sub-module, `pc_next_sel`: combinational priority mux over trap, redirect and sequential. It outputs the target address and the misalign flag.

## Test plan
- Reset release, memory acks every request on its first cycle, `inst_ready`=1 → `imem_addr` sequence 0,4,8,C; `inst_pc` matches each; one `inst_valid` every 2 cycles.
- Memory delays the ack 3 cycles, `inst_ready` low for 2 cycles → `imem_addr` stable throughout; `inst` held with `inst_valid`=1 until ready.
- `redirect_valid` with target 32'h100 during FETCH, ack 2 cycles later → DRAIN; the old data is never presented; the next `imem_addr`=32'h100.
- `trap` and `redirect_valid` (target 32'h200) in the same cycle → the next fetch is at `TRAP_VECTOR`.
- Redirect target 32'h102 → `misalign_err` pulses once; the next fetch is at `TRAP_VECTOR`.
- Redirect to 32'hFFFF_FFFC, ack, ready → next fetch at 32'h0; `reset_n` low mid-FETCH → `imem_req` drops asynchronously.
